// File: rtl/pipe_robot_ctrl_if.sv
// Sensor and command bundle between the pipe robot controller and its front-end/drivers.
// The slave side is the controller; the master side is the sensor front-end / driver harness.
interface pipe_robot_ctrl_if #(
  parameter int CNT_W = 8
);
  logic             head;
  logic             side;
  logic             under;
  logic             barrier;
  logic             front;
  logic             turn;
  logic             turn_dir;
  logic             remove;
  logic             done;
  logic             trapped;
  logic             blocked;
  logic [CNT_W-1:0] trash_count;

  modport master (
    output head, side, under, barrier,
    input  front, turn, turn_dir, remove, done, trapped, blocked, trash_count
  );

  modport slave (
    input  head, side, under, barrier,
    output front, turn, turn_dir, remove, done, trapped, blocked, trash_count
  );
endinterface

// File: rtl/pipe_robot_ctrl.sv
// Wall-following navigation and trash-removal controller for the pipe robot.
// All commands and flags are registered; terminal states hold until reset.
module pipe_robot_ctrl #(
  parameter bit FOLLOW_RIGHT = 1'b0,
  parameter int TURN_LIMIT   = 8,
  parameter int REMOVE_LIMIT = 4,
  parameter int CNT_W        = 8
) (
  input  logic               clock,
  input  logic               reset,
  pipe_robot_ctrl_if.slave   bus
);
  localparam logic [3:0] ST_INIT    = 4'd0;
  localparam logic [3:0] ST_FIRST   = 4'd1;
  localparam logic [3:0] ST_SEARCH  = 4'd2;
  localparam logic [3:0] ST_ROTATE  = 4'd3;
  localparam logic [3:0] ST_FOLLOW  = 4'd4;
  localparam logic [3:0] ST_REMOVE  = 4'd5;
  localparam logic [3:0] ST_DONE    = 4'd6;
  localparam logic [3:0] ST_BLOCKED = 4'd7;
  localparam logic [3:0] ST_TRAPPED = 4'd8;

  localparam int   TR_W   = $clog2(TURN_LIMIT + 1);
  localparam int   RR_W   = $clog2(REMOVE_LIMIT + 1);
  localparam logic TOWARD = FOLLOW_RIGHT;
  localparam logic AWAY   = ~FOLLOW_RIGHT;

  logic [3:0]      state_reg, state_next;
  logic [TR_W-1:0] turn_run_reg, turn_run_next;
  logic [RR_W-1:0] rem_run_reg, rem_run_next;
  logic [CNT_W-1:0] trash_count_reg, trash_count_next;
  logic front_reg, front_next, turn_reg, turn_next, dir_reg, dir_next;
  logic remove_reg, remove_next;
  logic done_reg, trapped_reg, blocked_reg;

  logic       want_front, want_turn, want_remove, want_dir;
  logic [3:0] target;
  logic [2:0] key;
  logic       terminal, active;

  assign key      = {bus.head, bus.side, bus.barrier};
  assign terminal = (state_reg == ST_DONE) || (state_reg == ST_BLOCKED) || (state_reg == ST_TRAPPED);
  assign active   = (state_reg == ST_SEARCH) || (state_reg == ST_ROTATE) ||
                    (state_reg == ST_FOLLOW) || (state_reg == ST_REMOVE);

  // Per-state sensor table: what the robot would like to do, before limits and overrides.
  always_comb begin
    want_front  = 1'b0;
    want_turn   = 1'b0;
    want_remove = 1'b0;
    want_dir    = AWAY;
    target      = state_reg;
    case (state_reg)
      ST_FIRST: begin
        if (key == 3'b010) begin
          want_front = 1'b1;
          target     = ST_SEARCH;
        end else if (key == 3'b011) begin
          want_remove = 1'b1;
        end else begin
          want_turn = 1'b1;
        end
      end
      ST_SEARCH: begin
        if (key == 3'b010) begin
          want_front = 1'b1;
        end else if (key == 3'b110) begin
          want_turn = 1'b1;
          target    = ST_ROTATE;
        end else if (key == 3'b011) begin
          want_remove = 1'b1;
          target      = ST_REMOVE;
        end else begin
          want_turn = 1'b1;
          want_dir  = TOWARD;
          target    = ST_FOLLOW;
        end
      end
      ST_ROTATE: begin
        if (key == 3'b010) begin
          want_front = 1'b1;
          target     = ST_SEARCH;
        end else if (key == 3'b011) begin
          want_remove = 1'b1;
          target      = ST_REMOVE;
        end else begin
          want_turn = 1'b1;
        end
      end
      ST_FOLLOW, ST_REMOVE: begin
        if (!bus.head && !bus.barrier) begin
          want_front = 1'b1;
          target     = ST_SEARCH;
        end else if (!bus.head) begin
          want_remove = 1'b1;
          target      = ST_REMOVE;
        end else if (bus.side) begin
          want_turn = 1'b1;
          target    = ST_ROTATE;
        end else begin
          want_turn = 1'b1;
          want_dir  = TOWARD;
          target    = ST_FOLLOW;
        end
      end
      default: ;
    endcase
  end

  // Priority resolution: terminal hold, exit marker, jammed barrier, run limits, then the table.
  always_comb begin
    state_next       = state_reg;
    front_next       = 1'b0;
    turn_next        = 1'b0;
    dir_next         = 1'b0;
    remove_next      = 1'b0;
    trash_count_next = trash_count_reg;
    if (terminal) begin
      state_next = state_reg;
    end else if (bus.under && active) begin
      state_next = ST_DONE;
    end else if (bus.head && bus.barrier && (state_reg != ST_INIT)) begin
      state_next = ST_BLOCKED;
    end else if (state_reg == ST_INIT) begin
      state_next = ST_FIRST;
    end else if (want_remove && (rem_run_reg == RR_W'(REMOVE_LIMIT))) begin
      state_next = ST_BLOCKED;
    end else if (want_turn && (turn_run_reg == TR_W'(TURN_LIMIT))) begin
      state_next = ST_TRAPPED;
    end else begin
      state_next  = target;
      front_next  = want_front;
      turn_next   = want_turn;
      dir_next    = want_turn & want_dir;
      remove_next = want_remove;
      if ((state_reg == ST_REMOVE) && !bus.barrier && (trash_count_reg != {CNT_W{1'b1}}))
        trash_count_next = trash_count_reg + CNT_W'(1);
    end
  end

  always_comb begin
    rem_run_next  = remove_next ? rem_run_reg + RR_W'(1) : '0;
    turn_run_next = turn_run_reg;
    if (turn_next)
      turn_run_next = turn_run_reg + TR_W'(1);
    else if (front_next || remove_next)
      turn_run_next = '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg       <= ST_INIT;
      turn_run_reg    <= '0;
      rem_run_reg     <= '0;
      trash_count_reg <= '0;
      front_reg       <= 1'b0;
      turn_reg        <= 1'b0;
      dir_reg         <= 1'b0;
      remove_reg      <= 1'b0;
      done_reg        <= 1'b0;
      trapped_reg     <= 1'b0;
      blocked_reg     <= 1'b0;
    end else begin
      state_reg       <= state_next;
      turn_run_reg    <= turn_run_next;
      rem_run_reg     <= rem_run_next;
      trash_count_reg <= trash_count_next;
      front_reg       <= front_next;
      turn_reg        <= turn_next;
      dir_reg         <= dir_next;
      remove_reg      <= remove_next;
      done_reg        <= (state_next == ST_DONE);
      trapped_reg     <= (state_next == ST_TRAPPED);
      blocked_reg     <= (state_next == ST_BLOCKED);
    end
  end

  assign bus.front       = front_reg;
  assign bus.turn        = turn_reg;
  assign bus.turn_dir    = dir_reg;
  assign bus.remove      = remove_reg;
  assign bus.done        = done_reg;
  assign bus.trapped     = trapped_reg;
  assign bus.blocked     = blocked_reg;
  assign bus.trash_count = trash_count_reg;
endmodule
